// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES byte-stream front end: block geometry,
// common data types and the byte-index to bit-position mapping used by both
// the byte-to-block assembler and the block-to-byte serializer.
package aes_stream_pkg;

   localparam int unsigned AES_BLOCK_BYTES = 32'd16;
   localparam int unsigned AES_WORD_BYTES  = 32'd4;

   typedef logic [7:0]   byte_t;
   typedef logic [31:0]  word_t;
   typedef logic [127:0] block_t;

   // FIPS-197 order puts byte 0 in the most significant lane. Returns the
   // MSB bit index of byte k inside an nbytes-wide vector, for use with -: 8.
   function automatic int unsigned fips_byte_msb(input int unsigned k,
                                                 input int unsigned nbytes);
      return (32'd8 * nbytes) - 32'd1 - (32'd8 * k);
   endfunction

endpackage : aes_stream_pkg

// File: rtl/block_out_buffer.sv
// Single-slot output register with valid/ready handshake. A load always wins
// over a handshake in the same cycle, so the slot stays FULL when the old
// block leaves and a new one arrives together. Data is held after the slot
// empties so the last block stays visible.
module block_out_buffer
   import aes_stream_pkg::*;
#(
   parameter int unsigned W = 32'd128
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_data,
   input  logic         i_out_ready,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   output logic         o_handshake
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]   r_state;
   logic [0:0]   w_state_nxt;
   logic [W-1:0] r_data;

   assign o_valid     = (r_state == ST_FULL);
   assign o_handshake = o_valid && i_out_ready;
   assign o_data      = r_data;

   // Next-state: a load fills the slot, a handshake without load empties it.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_EMPTY: begin
            if (i_load) w_state_nxt = ST_FULL;
            else        w_state_nxt = ST_EMPTY;
         end
         ST_FULL: begin
            if (i_load)           w_state_nxt = ST_FULL;
            else if (i_out_ready) w_state_nxt = ST_EMPTY;
            else                  w_state_nxt = ST_FULL;
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // Slot state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Block data register; only changes on load so it is stable while stalled.
   always_ff @(posedge clk) begin
      if (rst)         r_data <= '0;
      else if (i_load) r_data <= i_load_data;
      else             r_data <= r_data;
   end

endmodule : block_out_buffer

// File: rtl/serial_to_parallel.sv
// Byte-stream to block assembler. Bytes arrive one per cycle over
// valid/ready, are packed in FIPS-197 order into an accumulator, and each
// completed block is handed to a single-slot output buffer. The accumulator
// doubles as a second block of buffering when the output is stalled.
module serial_to_parallel
   import aes_stream_pkg::*;
#(
   parameter int unsigned BLOCK_BYTES = AES_BLOCK_BYTES
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     sync_clr,
   output logic [8*BLOCK_BYTES-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready
);

   localparam int unsigned W     = 32'd8 * BLOCK_BYTES;
   localparam int unsigned CNT_W = $clog2(BLOCK_BYTES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 32'd1);

   logic [W-1:0]     r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_acc_full;

   logic [W-1:0]     w_acc_next;
   logic [W-1:0]     w_load_data;
   logic             w_accept;
   logic             w_last;
   logic             w_hs;
   logic             w_drain;
   logic             w_load;

   // in_ready depends only on registered acc_full and the clear/reset inputs.
   assign in_ready = !r_acc_full && !sync_clr && !rst;
   assign w_accept = in_valid && in_ready;
   assign w_last   = w_accept && (r_cnt == CNT_LAST);

   // A pending block moves out on handshake unless it is being discarded.
   assign w_drain  = w_hs && r_acc_full && !sync_clr;
   assign w_load   = (w_last && (!out_valid || out_ready)) || w_drain;

   // Completed block goes straight out; a pending block comes from acc.
   assign w_load_data = r_acc_full ? r_acc : w_acc_next;

   // Accumulator with the incoming byte merged at lane r_cnt.
   for (genvar k = 0; k < BLOCK_BYTES; k++) begin : g_lane
      localparam int unsigned MSB = fips_byte_msb(k, BLOCK_BYTES);
      assign w_acc_next[MSB -: 8] = (r_cnt == CNT_W'(k)) ? in_data
                                                         : r_acc[MSB -: 8];
   end

   // Accumulator: capture each accepted byte in place.
   always_ff @(posedge clk) begin
      if (rst)           r_acc <= '0;
      else if (w_accept) r_acc <= w_acc_next;
      else               r_acc <= r_acc;
   end

   // Byte counter: advances per accepted byte, wraps at block end.
   always_ff @(posedge clk) begin
      if (rst)                r_cnt <= '0;
      else if (sync_clr)      r_cnt <= '0;
      else if (w_last)        r_cnt <= '0;
      else if (w_accept)      r_cnt <= r_cnt + CNT_W'(1);
      else                    r_cnt <= r_cnt;
   end

   // Pending-block flag: set when a block completes into a stalled output.
   always_ff @(posedge clk) begin
      if (rst)                                  r_acc_full <= 1'b0;
      else if (sync_clr)                        r_acc_full <= 1'b0;
      else if (w_drain)                         r_acc_full <= 1'b0;
      else if (w_last && out_valid && !out_ready) r_acc_full <= 1'b1;
      else                                      r_acc_full <= r_acc_full;
   end

   block_out_buffer #(
      .W (W)
   ) u_out_buf (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_load_data (w_load_data),
      .i_out_ready (out_ready),
      .o_data      (out_data),
      .o_valid     (out_valid),
      .o_handshake (w_hs)
   );

endmodule : serial_to_parallel

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel. A queue-based scoreboard holds
// the blocks expected in the output slot and the pending accumulator; it is
// advanced on every clock from the driven stimulus alone.
module tb_serial_to_parallel;
   import aes_stream_pkg::*;

   logic   clk;
   logic   rst;
   byte_t  in_data;
   logic   in_valid;
   logic   in_ready;
   logic   sync_clr;
   block_t out_data;
   logic   out_valid;
   logic   out_ready;

   block_t sb[$];
   block_t m_acc;
   block_t m_last;
   int     m_cnt;
   int     n_vec;
   int     n_err;

   serial_to_parallel #(.BLOCK_BYTES(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sync_clr  (sync_clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic exp_rdy();
      return !rst && !sync_clr && (sb.size() < 2);
   endfunction

   function automatic logic exp_vld();
      return sb.size() > 0;
   endfunction

   function automatic block_t exp_dat();
      return (sb.size() > 0) ? sb[0] : m_last;
   endfunction

   // Drive inputs (just after a rising edge) and wait to the sample point.
   task automatic apply(input logic v, input byte_t d, input logic r, input logic c);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      sync_clr  = c;
      @(negedge clk);
   endtask

   // Clock edge: update the reference model from the inputs just driven.
   task automatic advance();
      logic acc, hs;
      @(posedge clk);
      if (rst) begin
         sb.delete();
         m_last = '0;
         m_acc  = '0;
         m_cnt  = 0;
      end else begin
         acc = in_valid && exp_rdy();
         hs  = (sb.size() > 0) && out_ready;
         if (sync_clr) begin
            if (sb.size() == 2) void'(sb.pop_back());
            m_cnt = 0;
         end
         if (hs) m_last = sb.pop_front();
         if (acc) begin
            m_acc[127 - 8*m_cnt -: 8] = in_data;
            if (m_cnt == 15) begin
               sb.push_back(m_acc);
               m_cnt = 0;
            end else begin
               m_cnt++;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, 8'h5a, 1'b1, 1'b0);
         if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready cyc=%0d got=%b want=0", i, in_ready); end
         if (out_valid !== 1'b0 && i > 0) begin n_err++; $display("FAIL rst_out_valid cyc=%0d got=%b want=0", i, out_valid); end
         if (out_data !== 128'h0 && i > 0) begin n_err++; $display("FAIL rst_out_data cyc=%0d got=%h want=0", i, out_data); end
         n_vec += 3;
         advance();
      end
      rst = 1'b0;
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got=%b want=1", in_ready); end
      n_vec++;
      advance();
   endtask

   task automatic test_single_block();
      for (int i = 0; i < 17; i++) begin
         apply(i < 16, 8'(i * 17), 1'b1, 1'b0);
         if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL single_rdy cyc=%0d got=%b want=%b", i, in_ready, exp_rdy()); end
         if (out_valid !== exp_vld()) begin n_err++; $display("FAIL single_vld cyc=%0d got=%b want=%b", i, out_valid, exp_vld()); end
         if (out_data !== exp_dat()) begin n_err++; $display("FAIL single_dat cyc=%0d got=%h want=%h", i, out_data, exp_dat()); end
         n_vec += 3;
         if (i == 16) begin
            if (out_valid !== 1'b1 || out_data !== 128'h00112233445566778899aabbccddeeff) begin
               n_err++; $display("FAIL single_block got=%b/%h want=1/00112233445566778899aabbccddeeff", out_valid, out_data);
            end
            n_vec++;
         end
         advance();
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 33; i++) begin
         apply(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
         if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL bp_rdy cyc=%0d got=%b want=%b", i, in_ready, exp_rdy()); end
         if (out_valid !== exp_vld()) begin n_err++; $display("FAIL bp_vld cyc=%0d got=%b want=%b", i, out_valid, exp_vld()); end
         if (out_data !== exp_dat()) begin n_err++; $display("FAIL bp_dat cyc=%0d got=%h want=%h", i, out_data, exp_dat()); end
         n_vec += 3;
         advance();
      end
      apply(1'b1, 8'h77, 1'b0, 1'b0);
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall got=%b want=0", in_ready); end
      if (out_data !== 128'h404142434445464748494a4b4c4d4e4f) begin n_err++; $display("FAIL bp_first_held got=%h want=404142434445464748494a4b4c4d4e4f", out_data); end
      n_vec += 2;
      advance();
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      advance();
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_recover got=%b want=1", in_ready); end
      if (out_valid !== 1'b1 || out_data !== 128'h505152535455565758595a5b5c5d5e5f) begin
         n_err++; $display("FAIL bp_second got=%b/%h want=1/505152535455565758595a5b5c5d5e5f", out_valid, out_data);
      end
      n_vec += 2;
      advance();
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      advance();
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got=%b want=0", out_valid); end
      n_vec++;
      advance();
   endtask

   task automatic test_back_to_back();
      int pulses;
      pulses = 0;
      for (int i = 0; i < 49; i++) begin
         apply(i < 48, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
         if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL b2b_rdy cyc=%0d got=%b want=%b", i, in_ready, exp_rdy()); end
         if (out_valid !== exp_vld()) begin n_err++; $display("FAIL b2b_vld cyc=%0d got=%b want=%b", i, out_valid, exp_vld()); end
         if (out_data !== exp_dat()) begin n_err++; $display("FAIL b2b_dat cyc=%0d got=%h want=%h", i, out_data, exp_dat()); end
         n_vec += 3;
         if (out_valid === 1'b1) pulses++;
         advance();
      end
      if (pulses != 3) begin n_err++; $display("FAIL b2b_pulses got=%0d want=3", pulses); end
      n_vec++;
   endtask

   task automatic test_sync_clr();
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, 8'(8'h70 + i), 1'b1, 1'b0);
         advance();
      end
      apply(1'b1, 8'hee, 1'b1, 1'b1);
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL clr_ready got=%b want=0", in_ready); end
      n_vec++;
      advance();
      for (int i = 0; i < 17; i++) begin
         apply(i < 16, 8'(8'h0f - i), 1'b1, 1'b0);
         if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL clr_rdy cyc=%0d got=%b want=%b", i, in_ready, exp_rdy()); end
         if (out_valid !== exp_vld()) begin n_err++; $display("FAIL clr_vld cyc=%0d got=%b want=%b", i, out_valid, exp_vld()); end
         n_vec += 2;
         if (i == 16) begin
            if (out_valid !== 1'b1 || out_data !== 128'h0f0e0d0c0b0a09080706050403020100) begin
               n_err++; $display("FAIL clr_block got=%b/%h want=1/0f0e0d0c0b0a09080706050403020100", out_valid, out_data);
            end
            n_vec++;
         end
         advance();
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 26; i++) begin
         apply(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
         advance();
      end
      rst = 1'b1;
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      advance();
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      if (out_valid !== 1'b0 || out_data !== 128'h0) begin n_err++; $display("FAIL rstmid_out got=%b/%h want=0/0", out_valid, out_data); end
      n_vec++;
      advance();
      rst = 1'b0;
      for (int i = 0; i < 17; i++) begin
         apply(i < 16, 8'(8'hc0 + i), 1'b0, 1'b0);
         if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL rstmid_rdy cyc=%0d got=%b want=%b", i, in_ready, exp_rdy()); end
         if (out_data !== exp_dat()) begin n_err++; $display("FAIL rstmid_dat cyc=%0d got=%h want=%h", i, out_data, exp_dat()); end
         n_vec += 2;
         advance();
      end
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      if (out_valid !== 1'b1 || out_data !== 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf) begin
         n_err++; $display("FAIL rstmid_block got=%b/%h want=1/c0c1c2c3c4c5c6c7c8c9cacbcccdcecf", out_valid, out_data);
      end
      n_vec++;
      advance();
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_single got=%b want=0", out_valid); end
      n_vec++;
      advance();
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 31; i++) begin
         apply(1'b1, (i < 16) ? 8'(8'ha0 + i) : 8'(8'h30 + i - 16), 1'b0, 1'b0);
         advance();
      end
      apply(1'b1, 8'h3f, 1'b1, 1'b0);
      if (out_data !== 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf) begin n_err++; $display("FAIL simul_old got=%h want=a0a1a2a3a4a5a6a7a8a9aaabacadaeaf", out_data); end
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL simul_rdy got=%b want=1", in_ready); end
      n_vec += 2;
      advance();
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      if (out_valid !== 1'b1 || out_data !== 128'h303132333435363738393a3b3c3d3e3f) begin
         n_err++; $display("FAIL simul_new got=%b/%h want=1/303132333435363738393a3b3c3d3e3f", out_valid, out_data);
      end
      if (out_valid !== exp_vld() || out_data !== exp_dat()) begin n_err++; $display("FAIL simul_model got=%b/%h want=%b/%h", out_valid, out_data, exp_vld(), exp_dat()); end
      n_vec += 2;
      advance();
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      advance();
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      m_cnt     = 0;
      m_acc     = '0;
      m_last    = '0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      sync_clr  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      test_reset();
      test_single_block();
      test_backpressure();
      test_back_to_back();
      test_sync_clr();
      test_reset_mid();
      test_simultaneous();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_serial_to_parallel
